// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control bit positions, default widths
// and the MEM/WB occupancy state.
package pipe_pkg;

   localparam int unsigned DEF_DATA_W   = 32;
   localparam int unsigned DEF_NUM_DATA = 4;
   localparam int unsigned DEF_CTRL_W   = 4;

   // Control bundle bit positions, decoded downstream by the WB mux.
   localparam int unsigned RW_BIT       = 0;
   localparam int unsigned MEMTOREG_LO  = 1;
   localparam int unsigned MEMTOREG_HI  = 2;
   localparam int unsigned HALFBYTE_BIT = 3;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_e;

   // Number of entries held in a given occupancy state.
   function automatic logic [1:0] occ_count(input occ_e s);
      return 2'(s);
   endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the MEM/WB stage: {ctrl, data} with load enable
// and synchronous clear.
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int unsigned CTRL_W = DEF_CTRL_W,
   parameter int unsigned PAY_W  = DEF_DATA_W * DEF_NUM_DATA
) (
   input  logic              clk_i,
   input  logic              clr_i,
   input  logic              ld_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [PAY_W-1:0]  data_i,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [PAY_W-1:0]  data_o
);

   logic [CTRL_W-1:0] ctrl_q;
   logic [PAY_W-1:0]  data_q;

   // Clear wins over load; otherwise hold contents.
   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         ctrl_q <= '0;
         data_q <= '0;
      end else if (ld_i) begin
         ctrl_q <= ctrl_i;
         data_q <= data_i;
      end
   end

   assign ctrl_o = ctrl_q;
   assign data_o = data_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB boundary register: two-entry skid buffer with valid/ready
// flow control, synchronous flush and valid-gated RegWrite.
module mem_wb_stage #(
   parameter int unsigned DATA_W   = pipe_pkg::DEF_DATA_W,
   parameter int unsigned NUM_DATA = pipe_pkg::DEF_NUM_DATA,
   parameter int unsigned CTRL_W   = pipe_pkg::DEF_CTRL_W,
   parameter int unsigned RW_BIT   = pipe_pkg::RW_BIT
) (
   input  logic                       Clk,
   input  logic                       Rst,
   input  logic                       Flush,
   input  logic                       In_Valid,
   output logic                       In_Ready,
   input  logic [CTRL_W-1:0]          In_Ctrl,
   input  logic [NUM_DATA*DATA_W-1:0] In_Data,
   output logic                       Out_Valid,
   input  logic                       Out_Ready,
   output logic [CTRL_W-1:0]          Out_Ctrl,
   output logic [NUM_DATA*DATA_W-1:0] Out_Data,
   output logic                       Out_RegWrite,
   output logic [1:0]                 Occ
);

   import pipe_pkg::*;

   localparam int unsigned PAY_W = NUM_DATA * DATA_W;

   occ_e state_q, state_d;
   logic in_ready_q, in_ready_d;

   logic accept, release_h;
   logic head_ld, skid_ld, head_from_skid;

   logic [CTRL_W-1:0] head_ctrl, skid_ctrl, head_ctrl_in;
   logic [PAY_W-1:0]  head_data, skid_data, head_data_in;

   // In TWO the ready flop is low, so accept cannot fire there.
   assign accept    = In_Valid & in_ready_q;
   assign Out_Valid = (state_q != EMPTY);
   assign release_h = Out_Valid & Out_Ready;

   // Occupancy next state and slot load strobes; flush kills everything.
   always_comb begin
      state_d        = state_q;
      head_ld        = 1'b0;
      skid_ld        = 1'b0;
      head_from_skid = 1'b0;
      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d = ONE;
               head_ld = 1'b1;
            end
         end
         ONE: begin
            if (accept && release_h) begin
               head_ld = 1'b1;
            end else if (accept) begin
               state_d = TWO;
               skid_ld = 1'b1;
            end else if (release_h) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (release_h) begin
               state_d        = ONE;
               head_ld        = 1'b1;
               head_from_skid = 1'b1;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
      if (Flush) begin
         state_d        = EMPTY;
         head_ld        = 1'b0;
         skid_ld        = 1'b0;
         head_from_skid = 1'b0;
      end
      in_ready_d = (state_d != TWO);
   end

   // Occupancy and ready flops; reset also covers a coincident flush.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q    <= EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
      end
   end

   // Head refills from the skid when draining TWO, else from the input.
   always_comb begin
      head_ctrl_in = In_Ctrl;
      head_data_in = In_Data;
      if (head_from_skid) begin
         head_ctrl_in = skid_ctrl;
         head_data_in = skid_data;
      end
   end

   pipe_slot #(
      .CTRL_W (CTRL_W),
      .PAY_W  (PAY_W)
   ) u_head (
      .clk_i  (Clk),
      .clr_i  (Rst),
      .ld_i   (head_ld),
      .ctrl_i (head_ctrl_in),
      .data_i (head_data_in),
      .ctrl_o (head_ctrl),
      .data_o (head_data)
   );

   pipe_slot #(
      .CTRL_W (CTRL_W),
      .PAY_W  (PAY_W)
   ) u_skid (
      .clk_i  (Clk),
      .clr_i  (Rst),
      .ld_i   (skid_ld),
      .ctrl_i (In_Ctrl),
      .data_i (In_Data),
      .ctrl_o (skid_ctrl),
      .data_o (skid_data)
   );

   assign In_Ready     = in_ready_q;
   assign Out_Ctrl     = head_ctrl;
   assign Out_Data     = head_data;
   assign Out_RegWrite = Out_Valid & head_ctrl[RW_BIT];
   assign Occ          = occ_count(state_q);

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomised scoreboard bench for mem_wb_stage against a
// queue-based model of a two-deep registered-ready FIFO.
module tb_mem_wb_stage;

   localparam int DW = 32;
   localparam int ND = 4;
   localparam int CW = 4;
   localparam int PW = DW * ND;

   logic          Clk = 1'b0;
   logic          Rst, Flush, In_Valid, In_Ready;
   logic          Out_Valid, Out_Ready, Out_RegWrite;
   logic [CW-1:0] In_Ctrl, Out_Ctrl;
   logic [PW-1:0] In_Data, Out_Data;
   logic [1:0]    Occ;

   always #5 Clk = ~Clk;

   mem_wb_stage #(
      .DATA_W   (DW),
      .NUM_DATA (ND),
      .CTRL_W   (CW),
      .RW_BIT   (0)
   ) dut (
      .Clk          (Clk),
      .Rst          (Rst),
      .Flush        (Flush),
      .In_Valid     (In_Valid),
      .In_Ready     (In_Ready),
      .In_Ctrl      (In_Ctrl),
      .In_Data      (In_Data),
      .Out_Valid    (Out_Valid),
      .Out_Ready    (Out_Ready),
      .Out_Ctrl     (Out_Ctrl),
      .Out_Data     (Out_Data),
      .Out_RegWrite (Out_RegWrite),
      .Occ          (Occ)
   );

   typedef struct packed {
      logic [CW-1:0] c;
      logic [PW-1:0] d;
   } ent_t;

   ent_t sb_q[$];
   int   occ_m = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   bit   mon_en = 1'b0;

   task automatic chk(input string nm, input logic [PW-1:0] act,
                      input logic [PW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   function automatic logic [PW-1:0] mk(input logic [31:0] ch2);
      return {32'hDEAD_0000 + ch2, ch2,
              32'hBEEF_0000 + ch2, 32'h1000_0000 + ch2};
   endfunction

   // Reference model: bounded FIFO of depth 2 with ready = (count < 2)
   // taken from the count at the start of the cycle.
   initial begin
      bit acc, rel;
      forever begin
         @(posedge Clk);
         acc = (In_Valid === 1'b1) && (occ_m < 2);
         rel = (occ_m > 0) && (Out_Ready === 1'b1);
         if (Rst === 1'b1 || Flush === 1'b1) begin
            occ_m = 0;
            sb_q.delete();
         end else begin
            occ_m = occ_m + int'(acc) - int'(rel);
            if (acc) sb_q.push_back('{c: In_Ctrl, d: In_Data});
         end
      end
   end

   // Monitor: compare the presented head against the scoreboard and
   // retire it when the writeback side takes it.
   always @(negedge Clk) begin
      if (mon_en) begin
         logic exp_rw;
         exp_rw = (occ_m > 0 && sb_q.size() > 0) ? sb_q[0].c[0] : 1'b0;
         chk("occ", PW'(Occ), PW'(occ_m));
         chk("out_valid", PW'(Out_Valid), PW'(occ_m > 0));
         chk("in_ready", PW'(In_Ready), PW'(occ_m < 2));
         chk("regwrite", PW'(Out_RegWrite), PW'(exp_rw));
         if (Out_Valid === 1'b1) begin
            if (sb_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_out: got %0h expected none at %0t",
                        Out_Data, $time);
            end else begin
               chk("out_ctrl", PW'(Out_Ctrl), PW'(sb_q[0].c));
               chk("out_data", Out_Data, sb_q[0].d);
            end
         end
         if (occ_m > 0 && Out_Ready === 1'b1 && sb_q.size() > 0)
            void'(sb_q.pop_front());
      end
   end

   task automatic cyc(input logic v, input logic [CW-1:0] c,
                      input logic [PW-1:0] d, input logic ordy,
                      input logic fl, input logic rs);
      In_Valid  = v;
      In_Ctrl   = c;
      In_Data   = d;
      Out_Ready = ordy;
      Flush     = fl;
      Rst       = rs;
      @(posedge Clk);
      #1;
   endtask

   initial begin
      logic [PW-1:0] od;
      // Reset for two cycles, then idle.
      cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      mon_en = 1'b1;
      cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      chk("rst_valid", PW'(Out_Valid), '0);
      chk("rst_occ", PW'(Occ), '0);
      chk("rst_ready", PW'(In_Ready), PW'(1));
      chk("rst_data", Out_Data, '0);
      chk("rst_ctrl", PW'(Out_Ctrl), '0);
      cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      chk("idle_valid", PW'(Out_Valid), '0);

      // Full-rate stream.
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b1, 4'b0001, mk(32'(i)), 1'b1, 1'b0, 1'b0);
         od = Out_Data;
         chk("stream_occ", PW'(Occ), PW'(1));
         chk("stream_rw", PW'(Out_RegWrite), PW'(1));
         chk("stream_ch2", PW'(od[95:64]), PW'(i));
      end

      // Bubble after a RegWrite entry.
      cyc(1'b1, 4'b0001, mk(32'h55), 1'b1, 1'b0, 1'b0);
      chk("bub_rw1", PW'(Out_RegWrite), PW'(1));
      cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      chk("bub_rw0", PW'(Out_RegWrite), '0);
      chk("bub_valid", PW'(Out_Valid), '0);
      chk("bub_ctrl_hold", PW'(Out_Ctrl), PW'(4'b0001));

      // Stall: A then B fill both slots, then drain in order.
      cyc(1'b1, 4'h1, mk(32'hA), 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 4'h5, mk(32'hB), 1'b0, 1'b0, 1'b0);
      chk("stall_occ", PW'(Occ), PW'(2));
      chk("stall_ready", PW'(In_Ready), '0);
      chk("stall_head_a", Out_Data, mk(32'hA));
      cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      chk("drain_occ", PW'(Occ), PW'(1));
      chk("drain_ready", PW'(In_Ready), PW'(1));
      chk("drain_head_b", Out_Data, mk(32'hB));
      cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      chk("drain_empty", PW'(Occ), '0);

      // Flush with both slots full and C offered.
      cyc(1'b1, 4'h1, mk(32'hD1), 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 4'h1, mk(32'hD2), 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 4'h1, mk(32'hC), 1'b0, 1'b1, 1'b0);
      chk("fl_valid", PW'(Out_Valid), '0);
      chk("fl_rw", PW'(Out_RegWrite), '0);
      chk("fl_occ", PW'(Occ), '0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
         chk("fl_no_c", PW'(Out_Valid), '0);
      end

      // Reset mid-stall with Out_Ready high.
      cyc(1'b1, 4'h1, mk(32'hE1), 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 4'h3, mk(32'hE2), 1'b0, 1'b0, 1'b0);
      cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
      chk("rs2_valid", PW'(Out_Valid), '0);
      chk("rs2_occ", PW'(Occ), '0);
      chk("rs2_ready", PW'(In_Ready), PW'(1));
      chk("rs2_data", Out_Data, '0);
      chk("rs2_ctrl", PW'(Out_Ctrl), '0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
         chk("rs2_no_rel", PW'(Out_Valid), '0);
      end

      // Random traffic with occasional flush and reset.
      for (int i = 0; i < 800; i++) begin
         cyc(1'($urandom_range(0, 1)),
             4'($urandom),
             {$urandom, $urandom, $urandom, $urandom},
             ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 79) == 0));
      end
      cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      @(negedge Clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Parametrised MEM/WB pipeline boundary register with valid/ready flow control, a two-entry skid buffer, and synchronous flush. It sits between the memory-access stage and the writeback mux/register-file write port. It replaces the fixed single-flop MEM/WB latch, and it adds back-pressure, bubble insertion and valid-gated register writes.

## Interface
Parameters:
- DATA_W, 32, width of each data channel
- NUM_DATA, 4, number of data channels (PC+4, mem read, ALU result, RegDst by default)
- CTRL_W, 4, control bundle width
- RW_BIT, 0, index of the RegWrite bit inside the control bundle

Ports:
- Clk  in  1  clock; all state updates on the rising edge
- Rst  in  1  reset; synchronous, active-high
- Flush  in  1  kill all held entries (synchronous)
- In_Valid  in  1  MEM stage presents a valid entry
- In_Ready  out  1  stage can accept an entry this cycle (registered)
- In_Ctrl  in  CTRL_W  MEM control bundle
- In_Data  in  NUM_DATA*DATA_W  concatenated data channels, channel 0 in LSBs
- Out_Valid  out  1  head entry valid
- Out_Ready  in  1  writeback consumes head this cycle
- Out_Ctrl  out  CTRL_W  head control bundle
- Out_Data  out  NUM_DATA*DATA_W  head data channels
- Out_RegWrite  out  1  Out_Ctrl[RW_BIT] AND Out_Valid
- Occ  out  2  entries held (0..2)

## Operation
- Storage: a head slot drives the outputs; a skid slot catches the entry that arrives while the head is stalled.
- Accept = In_Valid & In_Ready. Release = Out_Valid & Out_Ready.
- State = occupancy: EMPTY(0), ONE(1), TWO(2).
- EMPTY:
  - accept → ONE; the entry loads into the head.
- ONE:
  - accept & release → ONE; the head reloads from the input.
  - accept only → TWO; the entry loads into the skid.
  - release only → EMPTY.
  - neither → hold.
- TWO:
  - In_Ready=0, so there are no accepts.
  - release → ONE; the skid moves to the head.
  - otherwise hold.
- Flush (Rst behaves identically for valid/occupancy):
  - next state EMPTY; an entry offered in the flush cycle is dropped.
  - Flush overrides any accept/release in that cycle.
  - Out_Valid falls the cycle after Flush.
- Flush clears valid only. Slot contents stay as they are, and Out_Ctrl/Out_Data are don't-care while Out_Valid=0.
- Out_RegWrite must never assert while Out_Valid=0. This guarantees that bubbles and flushed entries cannot write the register file.
- Data and control pass unmodified. There is no width conversion and no arithmetic.

## Timing
- Reset values:
  - Out_Valid=0, Out_RegWrite=0, Occ=0, In_Ready=1.
  - Out_Ctrl=0, Out_Data=0, and both slots are cleared.
- Latency: 1 cycle. An entry accepted at edge N is visible on Out_* after edge N.
- Throughput: 1 entry/cycle with Out_Ready held high. The skid stays empty in steady state.
- In_Ready is a flop: 1 in EMPTY/ONE, 0 in TWO.
  - It rises the cycle after a release from TWO.
  - It depends on no input combinationally.
- Out_Ready may toggle freely. Out_Valid must not drop without a release or a Flush/Rst.
- Ordering: FIFO. The skid entry is always older than any later input.
- Simultaneous Flush and Rst: treated as Rst.
- Rst mid-stall (TWO): both entries are lost and In_Ready=1 next cycle.

## Structure
- The shared package pipe_pkg holds:
  - control bit-position constants: RW_BIT=0, MEMTOREG_LO=1, MEMTOREG_HI=2, HALFBYTE_BIT=3
  - the default CTRL_W/DATA_W
  - a typedef for the occupancy state enum (EMPTY/ONE/TWO)
- The writeback mux decodes MemToReg/halfbyte from Out_Ctrl using the pipe_pkg constants. This block does not decode them.
- Sub-module pipe_slot holds {ctrl, data} with load enable and synchronous clear. It is instantiated twice (head, skid).
- The top level holds the occupancy FSM, the In_Ready flop and the output gating.

## Test plan
- Rst held 2 cycles, then released with In_Valid=0 → Out_Valid=0, Occ=0, In_Ready=1, Out_Data=0.
- Stream 8 entries with In_Ctrl=4'b0001, data channel 2 = 1..8, and Out_Ready=1 → each appears 1 cycle later in order, Occ stays 1, Out_RegWrite=1 on each.
- Out_Ready=0, then send A and B → Occ=2 and In_Ready=0 the next cycle. Raise Out_Ready → A, then B, are released in order, and In_Ready returns to 1 one cycle after A's release.
- With Occ=2, assert Flush for 1 cycle while In_Valid=1 with C → next cycle Out_Valid=0, Out_RegWrite=0, Occ=0, and C never appears.
- Ctrl=4'b0001 entry with a bubble following (In_Valid=0) → Out_RegWrite=1 for one cycle, then 0 while Out_Ctrl still holds 4'b0001.
- Assert Rst while Occ=2 and Out_Ready=1 in the same cycle → all outputs return to reset values and no entry is released afterward.
